// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
// Holds the FSM state enum, the latency counter width and the address error check.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W          = 4;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_LATENCY    = 2;
  localparam int DEF_DATA_WIDTH = 32;

  // Misaligned word access or any address bit set above the stored range.
  function automatic logic addr_err(input logic [31:0] addr, input int aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write with byte-lane mask, registered read; one access per cycle.
// Contents are deliberately never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder: resp_valid LATENCY cycles after acceptance, no new request until back in IDLE.
// Define DMEM_BYTE_ENABLE_EN to add the req_be store lane mask; otherwise stores write the full word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LATENCY    = DEF_LATENCY,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
`ifdef DMEM_BYTE_ENABLE_EN
  input  logic [3:0]            req_be,
`endif
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  stall
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [BE_W-1:0]       req_be_w;
  logic                  mem_en;
  logic [DATA_WIDTH-1:0] mem_rdata;

`ifdef DMEM_BYTE_ENABLE_EN
  assign req_be_w = req_be;
`else
  assign req_be_w = '1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    req_ready = 1'b0;
    stall     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) begin
          write_d = req_write;
          err_d   = addr_err(req_addr, ADDR_WIDTH);
          addr_d  = req_addr[ADDR_WIDTH+1:2];
          wdata_d = req_wdata;
          be_d    = req_be_w;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The array is touched only on the edge entering RESP; _d values cover the LATENCY=1 path from IDLE.
  assign mem_en = !reset && (state_q != RESP) && (state_d == RESP) && !err_d;

  dmem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk     (clk),
    .en_i    (mem_en),
    .we_i    (write_d),
    .addr_i  (addr_d),
    .wdata_i (wdata_d),
    .be_i    (be_d),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && !write_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 1) driven with directed and random
// requests, checked against a word-map reference model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rv   [2];
  logic        rw   [2];
  logic [31:0] ra   [2];
  logic [31:0] rwd  [2];
  logic [3:0]  rbe  [2];
  logic        rrdy [2];
  logic        pv   [2];
  logic [31:0] prd  [2];
  logic        perr [2];
  logic        stl  [2];

  int vectors     = 0;
  int miscompares = 0;
  int lat_of [2]  = '{2, 1};
  logic [31:0] ref_mem [int];

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2), .DATA_WIDTH(32)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_write(rw[0]),
    .req_addr(ra[0]), .req_wdata(rwd[0]),
`ifdef DMEM_BYTE_ENABLE_EN
    .req_be(rbe[0]),
`endif
    .req_ready(rrdy[0]), .resp_valid(pv[0]), .resp_rdata(prd[0]),
    .resp_err(perr[0]), .stall(stl[0])
  );

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1), .DATA_WIDTH(32)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_write(rw[1]),
    .req_addr(ra[1]), .req_wdata(rwd[1]),
`ifdef DMEM_BYTE_ENABLE_EN
    .req_be(rbe[1]),
`endif
    .req_ready(rrdy[1]), .resp_valid(pv[1]), .resp_rdata(prd[1]),
    .resp_err(perr[1]), .stall(stl[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete request/response; expectations come from the word map and the address rules.
  task automatic txn(input int i, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be, output logic [31:0] got);
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] w;
    logic [3:0]  eff_be;
    int          key;
    int          lat;
    exp_err = (addr % 4 != 0) || (addr >= 32'd4096);
    key     = i * 65536 + int'(addr / 4);
    exp_rd  = 32'h0;
    if (!wr && !exp_err && ref_mem.exists(key)) exp_rd = ref_mem[key];
`ifdef DMEM_BYTE_ENABLE_EN
    eff_be = be;
`else
    eff_be = 4'hF;
`endif
    @(negedge clk);
    rv[i] = 1'b1; rw[i] = wr; ra[i] = addr; rwd[i] = wd; rbe[i] = be;
    #1;
    check("ready_idle", 32'(rrdy[i]), 32'd1);
    check("stall_req", 32'(stl[i]), 32'd1);
    @(posedge clk);
    #1;
    rv[i] = 1'b0; rw[i] = 1'($urandom); ra[i] = $urandom; rwd[i] = $urandom; rbe[i] = 4'($urandom);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (pv[i]) begin
        lat = k;
        break;
      end
      check("stall_wait", 32'(stl[i]), 32'd1);
      check("ready_wait", 32'(rrdy[i]), 32'd0);
    end
    check("latency", 32'(lat), 32'(lat_of[i]));
    check("resp_err", 32'(perr[i]), 32'(exp_err));
    check("resp_rdata", prd[i], exp_rd);
    check("stall_resp", 32'(stl[i]), 32'd0);
    check("ready_resp", 32'(rrdy[i]), 32'd0);
    got = prd[i];
    if (wr && !exp_err) begin
      w = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
      for (int b = 0; b < 4; b++) if (eff_be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
      ref_mem[key] = w;
    end
    @(negedge clk);
    check("ready_after", 32'(rrdy[i]), 32'd1);
    check("valid_after", 32'(pv[i]), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] addr;
    int          r;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = 32'h0; rwd[i] = 32'h0; rbe[i] = 4'hF;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", 32'(rrdy[i]), 32'd1);
      check("rst_valid", 32'(pv[i]), 32'd0);
      check("rst_rdata", prd[i], 32'd0);
      check("rst_err", 32'(perr[i]), 32'd0);
      check("rst_stall", 32'(stl[i]), 32'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < 2; i++)
      for (int wd = 0; wd < 16; wd++) txn(i, 1'b1, 32'(wd * 4), $urandom, 4'hF, got);

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, got);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, got);
    check("load_deadbeef", got, 32'hDEADBEEF);
    txn(0, 1'b0, 32'h13, 32'h0, 4'hF, got);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, got);
    check("after_misalign", got, 32'hDEADBEEF);
    txn(0, 1'b1, 32'h00001000, 32'hCAFEF00D, 4'hF, got);
    txn(0, 1'b0, 32'h0, 32'h0, 4'hF, got);

    // Reset lands on the WAIT cycle of a store, which must not commit.
    txn(0, 1'b1, 32'h20, 32'h11111111, 4'hF, got);
    @(negedge clk);
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h20; rwd[0] = 32'h22222222; rbe[0] = 4'hF;
    @(posedge clk);
    #1;
    rv[0] = 1'b0;
    @(negedge clk);
    check("wait_stall", 32'(stl[0]), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(pv[0]), 32'd0);
    check("abort_ready", 32'(rrdy[0]), 32'd1);
    check("abort_stall", 32'(stl[0]), 32'd0);
    @(negedge clk);
    check("abort_valid2", 32'(pv[0]), 32'd0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, got);
    check("abort_nocommit", got, 32'h11111111);

    txn(1, 1'b0, 32'h0, 32'h0, 4'hF, got);
    txn(1, 1'b0, 32'h6, 32'h0, 4'hF, got);

`ifdef DMEM_BYTE_ENABLE_EN
    txn(0, 1'b1, 32'h40, 32'hAABBCCDD, 4'hF, got);
    txn(0, 1'b1, 32'h40, 32'h11223344, 4'b0101, got);
    txn(0, 1'b0, 32'h40, 32'h0, 4'b0000, got);
    check("be_merge", got, 32'hAA22CC44);
    txn(0, 1'b1, 32'h40, 32'h55667788, 4'b0000, got);
    txn(0, 1'b0, 32'h40, 32'h0, 4'hF, got);
    check("be_noop", got, 32'hAA22CC44);
`endif

    for (int n = 0; n < 80; n++) begin
      r    = $urandom_range(0, 9);
      addr = 32'($urandom_range(0, 15) * 4);
      if (r == 0) addr = addr | 32'($urandom_range(1, 3));
      else if (r == 1) addr = addr | 32'h00001000 | ($urandom & 32'hFFFF_F000);
      txn((n < 60) ? 0 : 1, 1'($urandom), addr, $urandom, 4'($urandom), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
